// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular {pc, instr} trace capture with arm/trigger/post-count and indexed readback
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   valid_in/pc_in/instr_in   fetched sample stream
//   arm                  clear buffer and start recording (ARMED)
//   trig_mode/trig_pc/trig_op   trigger select: 0 immediate, 1 pc match, 2 opcode match, 3 never
//   post_count           samples recorded after the trigger sample
//   rd_en/rd_addr        read request (DONE only), index 0 = oldest entry
//   rd_data/rd_valid     registered read result, one cycle after rd_en
//   state_o/done         0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   fill/overflow/trig_lost   occupancy and sticky wrap indicators
module cpu_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [ADDR_W-1:0]        pc_in,
    input  logic [DATA_W-1:0]        instr_in,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [ADDR_W-1:0]        trig_pc,
    input  logic [5:0]               trig_op,
    input  logic [CNT_W-1:0]         post_count,
    input  logic                     rd_en,
    input  logic [PW-1:0]            rd_addr,
    output logic [ADDR_W+DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic [1:0]               state_o,
    output logic                     done,
    output logic [PW:0]              fill,
    output logic                     overflow,
    output logic                     trig_lost
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    state_t                    state, state_nxt;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             trig_ptr;
    logic [CNT_W-1:0]          remaining, remaining_nxt;
    logic [ADDR_W+DATA_W-1:0]  mem [DEPTH];

    logic                      full;
    logic                      wr_en;
    logic                      hit;
    logic [PW-1:0]             rd_phys;
    logic                      rd_in_range;

    assign full    = (fill == FULL);
    // arm wins over the write: a sample in the arm cycle is dropped
    assign wr_en   = valid_in && !arm && (state == S_ARMED || state == S_CAPTURE);
    assign state_o = state;
    assign done    = (state == S_DONE);

    always_comb begin
        hit = 1'b0;
        case (trig_mode)
            2'd0:    hit = 1'b1;
            2'd1:    hit = (pc_in == trig_pc);
            2'd2:    hit = (instr_in[31:26] == trig_op);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        if (arm) begin
            state_nxt = S_ARMED;
        end else if (wr_en) begin
            if (state == S_ARMED) begin
                if (hit) begin
                    if (post_count == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt     = S_CAPTURE;
                        remaining_nxt = post_count;
                    end
                end
            end else begin
                remaining_nxt = remaining - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            wr_ptr    <= '0;
            trig_ptr  <= '0;
            fill      <= '0;
            overflow  <= 1'b0;
            trig_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            if (arm) begin
                wr_ptr    <= '0;
                fill      <= '0;
                overflow  <= 1'b0;
                trig_lost <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    fill <= fill + 1'b1;
                end
                if (state == S_ARMED && hit) begin
                    trig_ptr <= wr_ptr;
                end
                // Post-trigger writes only reach trig_ptr again after a full lap
                if (state == S_CAPTURE && wr_ptr == trig_ptr) begin
                    trig_lost <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {pc_in, instr_in};
        end
    end

    // Once wrapped, the oldest entry sits at wr_ptr; before that it is slot 0
    assign rd_phys     = (full ? wr_ptr : '0) + rd_addr;
    assign rd_in_range = ({1'b0, rd_addr} < fill);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (state == S_DONE && rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_in_range ? mem[rd_phys] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
